// File: rtl/bitstream_loader_pkg.sv
// Shared types and defaults for the byte-serial bitstream loader.
package bitstream_loader_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_LEN,
    ERR_CSUM,
    ERR_TIMEOUT
  } err_code_e;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_CF61;

endpackage

// File: rtl/bitstream_word_asm.sv
// Packs MSB-first bytes into 32-bit words; word_valid fires combinationally with the 4th byte.
module bitstream_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  assign word       = {shift_q, byte_data};
  assign word_valid = byte_valid && (cnt_q == 2'd3);

  // A clear in the same cycle as a byte drops that byte too.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_valid) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {shift_q[15:0], byte_data};
    end
  end

endmodule

// File: rtl/bitstream_loader.sv
// Framed bitstream receiver: hunts for sync, reads length, streams payload words, verifies checksum.
module bitstream_loader
  import bitstream_loader_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       byte_data_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  input  logic             clear_i,
  output logic [31:0]      bitstream_data_o,
  output logic             bitstream_valid_o,
  output logic             done_o,
  output logic             error_o,
  output logic [1:0]       err_code_o,
  output logic [LEN_W-1:0] words_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  err_code_e         code_q, code_d;
  logic [31:0]       win_q, win_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic [31:0]       csum_q, csum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              ready_q, ready_d;

  logic        accept;
  logic        in_frame;
  logic [31:0] word;
  logic        word_valid;

  assign accept   = byte_valid_i && ready_q;
  assign in_frame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHECK);

  // Partial words never survive a state change (including timeout and clear).
  bitstream_word_asm u_word_asm (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (state_d != state_q),
    .byte_data  (byte_data_i),
    .byte_valid (accept && in_frame),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    win_d   = win_q;
    len_d   = len_q;
    words_d = words_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = done_q;
    error_d = error_q;

    if (in_frame) begin
      tmo_d = accept ? '0 : tmo_q + TMO_W'(1);
    end

    unique case (state_q)
      HUNT: begin
        if (accept) begin
          win_d = {win_q[23:0], byte_data_i};
          if (win_d == SYNC_WORD) begin
            state_d = LEN;
            words_d = '0;
            csum_d  = '0;
            tmo_d   = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
            code_d  = ERR_NONE;
          end
        end
      end
      LEN: begin
        if (word_valid) begin
          if ((word >> LEN_W) != 32'd0) begin
            state_d = ERROR;
            error_d = 1'b1;
            code_d  = ERR_LEN;
          end else begin
            len_d   = word[LEN_W-1:0];
            state_d = (word == 32'd0) ? CHECK : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (word_valid) begin
          data_d  = word;
          valid_d = 1'b1;
          words_d = words_q + LEN_W'(1);
          csum_d  = csum_q + word;
          if (words_d == len_q) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (word_valid) begin
          if (word == csum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
            code_d  = ERR_CSUM;
          end
        end
      end
      DONE, ERROR: begin
        if (clear_i) begin
          state_d = HUNT;
          done_d  = 1'b0;
          error_d = 1'b0;
          code_d  = ERR_NONE;
          win_d   = '0;
        end
      end
      default: state_d = HUNT;
    endcase

    // An accepted byte always restarts the idle count, so no word can coincide with a timeout.
    if (in_frame && !accept && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
      state_d = ERROR;
      error_d = 1'b1;
      code_d  = ERR_TIMEOUT;
    end

    ready_d = !((state_d == DONE) || (state_d == ERROR));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HUNT;
      code_q  <= ERR_NONE;
      win_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      win_q   <= win_d;
      len_q   <= len_d;
      words_q <= words_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      error_q <= error_d;
      ready_q <= ready_d;
    end
  end

  assign byte_ready_o      = ready_q;
  assign bitstream_data_o  = data_q;
  assign bitstream_valid_o = valid_q;
  assign done_o            = done_q;
  assign error_o           = error_q;
  assign err_code_o        = code_q;
  assign words_o           = words_q;

endmodule

// File: tb/tb_bitstream_loader.sv
// Directed bench for bitstream_loader with hand-computed expectations.
module tb_bitstream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        clear;
  logic [31:0] bs_data;
  logic        bs_valid;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] words;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int w0_cyc, w1_cyc;

  logic [31:0] sdata[$];
  int          scyc[$];

  localparam logic [31:0] SYNC = 32'hFAB0_CF61;

  bitstream_loader #(
    .SYNC_WORD      (SYNC),
    .LEN_W          (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .byte_data_i       (byte_data),
    .byte_valid_i      (byte_valid),
    .byte_ready_o      (byte_ready),
    .clear_i           (clear),
    .bitstream_data_o  (bs_data),
    .bitstream_valid_o (bs_valid),
    .done_o            (done),
    .error_o           (error),
    .err_code_o        (err_code),
    .words_o           (words)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bs_valid) begin
      sdata.push_back(bs_data);
      scyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    check_eq("ready_before_byte", {31'd0, byte_ready}, 32'd1);
    byte_data  = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    byte_valid = 1'b0;
    clear      = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
  endtask

  task automatic send_nominal(input logic [31:0] csum);
    send_word(SYNC);
    send_word(32'd2);
    send_word(32'h1122_3344);
    w0_cyc = last_acc;
    send_word(32'hA5A5_A5A5);
    w1_cyc = last_acc;
    send_word(csum);
    go_idle();
    tick(2);
  endtask

  initial begin
    rst        = 1'b1;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    clear      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, byte_ready}, 32'd1);
    check_eq("rst_valid", {31'd0, bs_valid}, 32'd0);
    check_eq("rst_data", bs_data, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_error", {31'd0, error}, 32'd0);
    check_eq("rst_code", {30'd0, err_code}, 32'd0);
    check_eq("rst_words", {16'd0, words}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal frame
    sdata.delete(); scyc.delete();
    send_nominal(32'hB6C7_D8E9);
    check_eq("nom_strobes", sdata.size(), 32'd2);
    if (sdata.size() == 2) begin
      check_eq("nom_w0", sdata[0], 32'h1122_3344);
      check_eq("nom_w1", sdata[1], 32'hA5A5_A5A5);
      check_eq("nom_w0_latency", scyc[0], w0_cyc);
      check_eq("nom_w1_latency", scyc[1], w1_cyc);
    end
    check_eq("nom_hold_data", bs_data, 32'hA5A5_A5A5);
    check_eq("nom_done", {31'd0, done}, 32'd1);
    check_eq("nom_error", {31'd0, error}, 32'd0);
    check_eq("nom_words", {16'd0, words}, 32'd2);
    check_eq("nom_code", {30'd0, err_code}, 32'd0);
    check_eq("nom_ready", {31'd0, byte_ready}, 32'd0);
    clear_pulse();
    check_eq("nom_clr_ready", {31'd0, byte_ready}, 32'd1);
    check_eq("nom_clr_done", {31'd0, done}, 32'd0);

    // Misaligned garbage before sync, zero-length frame
    sdata.delete(); scyc.delete();
    send_byte(8'h00);
    send_byte(8'hFA);
    send_word(SYNC);
    send_word(32'd0);
    send_word(32'd0);
    go_idle();
    tick(2);
    check_eq("hunt_strobes", sdata.size(), 32'd0);
    check_eq("hunt_done", {31'd0, done}, 32'd1);
    check_eq("hunt_words", {16'd0, words}, 32'd0);
    clear_pulse();

    // Bad checksum
    sdata.delete(); scyc.delete();
    send_nominal(32'd0);
    check_eq("csum_strobes", sdata.size(), 32'd2);
    check_eq("csum_error", {31'd0, error}, 32'd1);
    check_eq("csum_code", {30'd0, err_code}, 32'd2);
    check_eq("csum_done", {31'd0, done}, 32'd0);
    check_eq("csum_words", {16'd0, words}, 32'd2);
    clear_pulse();

    // Length overflow
    sdata.delete(); scyc.delete();
    send_word(SYNC);
    send_word(32'h0001_0000);
    go_idle();
    tick(2);
    check_eq("ovf_strobes", sdata.size(), 32'd0);
    check_eq("ovf_error", {31'd0, error}, 32'd1);
    check_eq("ovf_code", {30'd0, err_code}, 32'd1);
    check_eq("ovf_ready", {31'd0, byte_ready}, 32'd0);
    clear_pulse();
    check_eq("ovf_clr_ready", {31'd0, byte_ready}, 32'd1);
    check_eq("ovf_clr_error", {31'd0, error}, 32'd0);
    check_eq("ovf_clr_code", {30'd0, err_code}, 32'd0);

    // Timeout after two payload bytes
    sdata.delete(); scyc.delete();
    send_word(SYNC);
    send_word(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    go_idle();
    tick(6);
    check_eq("tmo_early_error", {31'd0, error}, 32'd0);
    tick(3);
    check_eq("tmo_error", {31'd0, error}, 32'd1);
    check_eq("tmo_code", {30'd0, err_code}, 32'd3);
    check_eq("tmo_strobes", sdata.size(), 32'd0);
    check_eq("tmo_words", {16'd0, words}, 32'd0);
    clear_pulse();
    send_nominal(32'hB6C7_D8E9);
    check_eq("tmo_reload_strobes", sdata.size(), 32'd2);
    check_eq("tmo_reload_done", {31'd0, done}, 32'd1);
    check_eq("tmo_reload_words", {16'd0, words}, 32'd2);
    clear_pulse();

    // Reset coinciding with the last byte of the second word
    sdata.delete(); scyc.delete();
    send_word(SYNC);
    send_word(32'd2);
    send_word(32'h1122_3344);
    check_eq("mid_words_before", {16'd0, words}, 32'd1);
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'hA5);
    @(negedge clk);
    byte_data = 8'hA5;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_valid", {31'd0, bs_valid}, 32'd0);
    check_eq("mid_rst_words", {16'd0, words}, 32'd0);
    check_eq("mid_rst_data", bs_data, 32'd0);
    check_eq("mid_rst_ready", {31'd0, byte_ready}, 32'd1);
    check_eq("mid_rst_strobes", sdata.size(), 32'd1);
    @(negedge clk);
    rst        = 1'b0;
    byte_valid = 1'b0;
    sdata.delete(); scyc.delete();
    send_nominal(32'hB6C7_D8E9);
    check_eq("post_rst_strobes", sdata.size(), 32'd2);
    check_eq("post_rst_done", {31'd0, done}, 32'd1);
    check_eq("post_rst_words", {16'd0, words}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
